// File: rtl/spi_fifo_master.sv
// Mode-0 SPI master that pops words from a TX FIFO, shifts them out MSB-first
// and hands each concurrently captured word to an RX FIFO as a one-cycle strobe.
module spi_fifo_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  rx_full,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  phase_end;
  logic                  start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    mosi_d     = mosi_q;
    fifo_rd_en = 1'b0;
    phase_end  = (cnt_q == CW'(CLK_DIV - 1));
    // A pop is never issued while reset is held, so no TX word is consumed then.
    start      = !rst && enable && !fifo_empty && !rx_full;

    case (state_q)
      IDLE: begin
        if (start) begin
          fifo_rd_en = 1'b1;
          tx_shift_d = fifo_rd_data;
          mosi_d     = fifo_rd_data[DATA_WIDTH-1];
          bit_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d    = HIGH;
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_d    = LOW;
          bit_d      = bit_q + 1'b1;
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          mosi_d     = tx_shift_q[DATA_WIDTH-2];
        end
      end
      LOW: begin
        if (phase_end) begin
          if (bit_q == BW'(DATA_WIDTH)) begin
            state_d   = DONE;
            rx_data_d = rx_shift_q;
          end else begin
            state_d    = HIGH;
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Pin outputs are registered, so they follow the state being entered.
    sclk_d     = (state_d == HIGH);
    cs_n_d     = !((state_d == SETUP) || (state_d == HIGH) || (state_d == LOW));
    rx_valid_d = (state_d == DONE);
  end

  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_fifo_master.sv
// Directed bench for spi_fifo_master: loopback transfers, FIFO/RX backpressure,
// back-to-back words, mid-word reset and a CLK_DIV=1 instance.
module tb_spi_fifo_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       enable, fifo_empty, fifo_rd_en, rx_full, rx_valid, busy;
  logic       sclk, mosi, miso, cs_n;
  logic [7:0] fifo_rd_data, rx_data;

  logic       en1, empty1, rd1, rv1, busy1, sclk1, mosi1, cs1;
  logic [7:0] rdd1, rxd1;
  logic       miso1, rxfull1;

  assign miso = mosi;

  spi_fifo_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .rx_full(rx_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_fifo_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1),
    .fifo_rd_en(rd1), .fifo_rd_data(rdd1), .rx_full(rxfull1),
    .rx_data(rxd1), .rx_valid(rv1), .busy(busy1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso1), .cs_n(cs1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  txq[$];
  int          rd_cyc[$];
  int          rv_cyc[$];
  logic [7:0]  rv_dat[$];
  logic [31:0] mosi_bits;
  int          n_rise;
  logic        csn_log[0:255];
  logic        sclk_log[0:255];
  logic        busy_log[0:255];

  task automatic sync_fifo();
    fifo_empty   = (txq.size() == 0);
    fifo_rd_data = (txq.size() != 0) ? txq[0] : 8'h00;
  endtask

  task automatic clear_log();
    rd_cyc.delete();
    rv_cyc.delete();
    rv_dat.delete();
    mosi_bits = '0;
    n_rise    = 0;
    for (int k = 0; k < 256; k++) begin
      csn_log[k] = 1'b0; sclk_log[k] = 1'b0; busy_log[k] = 1'b0;
    end
  endtask

  // Runs n cycles of the CLK_DIV=4 instance; cycle 0 is the first cycle run.
  task automatic run(input int n, input int rst_at, input int rst_rel, input int rxf_rel);
    logic prev, do_pop;
    prev = sclk;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at)  rst = 1'b1;
      if (i == rst_rel) rst = 1'b0;
      if (i == rxf_rel) rx_full = 1'b0;
      @(negedge clk);
      if (i < 256) begin
        csn_log[i] = cs_n; sclk_log[i] = sclk; busy_log[i] = busy;
      end
      if (fifo_rd_en) rd_cyc.push_back(i);
      if (rx_valid) begin
        rv_cyc.push_back(i); rv_dat.push_back(rx_data);
      end
      if (sclk && !prev) begin
        mosi_bits = {mosi_bits[30:0], mosi};
        n_rise++;
      end
      prev   = sclk;
      do_pop = fifo_rd_en;
      @(posedge clk);
      #1;
      if (do_pop) void'(txq.pop_front());
      sync_fifo();
    end
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    rst = 1'b1; enable = 1'b0; rx_full = 1'b0;
    en1 = 1'b0; empty1 = 1'b1; rdd1 = 8'h00; miso1 = 1'b0; rxfull1 = 1'b0;
    sync_fifo();
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single loopback word
    txq.push_back(8'hA5); sync_fifo(); enable = 1'b1;
    clear_log();
    run(75, -1, -1, -1);
    check("t1_pops", rd_cyc.size(), 1);
    check("t1_pop_cyc", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, 0);
    check("t1_sclk_rises", n_rise, 8);
    check("t1_mosi_bits", mosi_bits[7:0], 8'hA5);
    check("t1_rv_count", rv_cyc.size(), 1);
    check("t1_rv_cyc", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, 69);
    check("t1_rv_data", (rv_dat.size() > 0) ? rv_dat[0] : 8'hxx, 8'hA5);
    check("t1_csn_c0", csn_log[0], 1'b1);
    check("t1_csn_c1", csn_log[1], 1'b0);
    check("t1_csn_c68", csn_log[68], 1'b0);
    check("t1_csn_c69", csn_log[69], 1'b1);
    check("t1_busy_c0", busy_log[0], 1'b0);
    check("t1_busy_c1", busy_log[1], 1'b1);

    // Empty FIFO with enable held
    clear_log();
    run(100, -1, -1, -1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy_log[k]) cnt_a++;
      if (!csn_log[k]) cnt_b++;
      if (sclk_log[k]) cnt_c++;
    end
    check("t2_pops", rd_cyc.size(), 0);
    check("t2_rv", rv_cyc.size(), 0);
    check("t2_busy_cycles", cnt_a, 0);
    check("t2_csn_low_cycles", cnt_b, 0);
    check("t2_sclk_high_cycles", cnt_c, 0);

    // RX FIFO full holds off the pop
    rx_full = 1'b1; txq.push_back(8'h3C); sync_fifo();
    clear_log();
    run(95, -1, -1, 20);
    check("t3_pops", rd_cyc.size(), 1);
    check("t3_pop_cyc", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, 20);
    check("t3_rv_cyc", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, 89);
    check("t3_rv_data", (rv_dat.size() > 0) ? rv_dat[0] : 8'hxx, 8'h3C);

    // Back-to-back words
    txq.push_back(8'h12); txq.push_back(8'hF0); sync_fifo();
    clear_log();
    run(145, -1, -1, -1);
    cnt_a = 0;
    for (int k = 1; k < 139; k++) if (csn_log[k]) cnt_a++;
    check("t4_pop2_cyc", (rd_cyc.size() > 1) ? rd_cyc[1] : -1, 70);
    check("t4_rv_count", rv_cyc.size(), 2);
    check("t4_rv0_cyc", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, 69);
    check("t4_rv0_data", (rv_dat.size() > 0) ? rv_dat[0] : 8'hxx, 8'h12);
    check("t4_rv1_cyc", (rv_cyc.size() > 1) ? rv_cyc[1] : -1, 139);
    check("t4_rv1_data", (rv_dat.size() > 1) ? rv_dat[1] : 8'hxx, 8'hF0);
    check("t4_csn_high_gap", cnt_a, 2);
    check("t4_csn_c69_c70", {30'd0, csn_log[69], csn_log[70]}, 32'd3);

    // Reset in the middle of a word
    txq.push_back(8'hA5); txq.push_back(8'h81); sync_fifo();
    clear_log();
    run(110, 30, 32, -1);
    check("t5_csn_c30", csn_log[30], 1'b1);
    check("t5_sclk_c30", sclk_log[30], 1'b0);
    check("t5_busy_c30", busy_log[30], 1'b0);
    check("t5_pops", rd_cyc.size(), 2);
    check("t5_pop2_cyc", (rd_cyc.size() > 1) ? rd_cyc[1] : -1, 32);
    check("t5_rv_count", rv_cyc.size(), 1);
    check("t5_rv_cyc", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, 101);
    check("t5_rv_data", (rv_dat.size() > 0) ? rv_dat[0] : 8'hxx, 8'h81);

    // CLK_DIV=1 instance, miso tied low
    enable = 1'b0;
    en1 = 1'b1; empty1 = 1'b0; rdd1 = 8'hFF;
    begin
      int   pop_c, rv_c, toggles, rises;
      logic [7:0] rv_d, bits;
      logic prev_s, rd_s;
      pop_c = -1; rv_c = -1; toggles = 0; rises = 0; rv_d = 8'hxx; bits = 8'h00;
      prev_s = sclk1;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (rd1 && pop_c < 0) pop_c = i;
        if (rv1) begin rv_c = i; rv_d = rxd1; end
        if (i >= 2 && i <= 17 && sclk1 != prev_s) toggles++;
        if (sclk1 && !prev_s) begin rises++; bits = {bits[6:0], mosi1}; end
        prev_s = sclk1;
        rd_s = rd1;
        @(posedge clk);
        #1;
        if (rd_s) empty1 = 1'b1;
      end
      check("t6_pop_cyc", pop_c, 0);
      check("t6_sclk_toggles", toggles, 16);
      check("t6_sclk_rises", rises, 8);
      check("t6_mosi_bits", bits, 8'hFF);
      check("t6_rv_cyc", rv_c, 18);
      check("t6_rv_data", rv_d, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
